// File: rtl/rdout_wout_drain.sv
// rtl/rdout_wout_drain.sv - snapshots trainer W_out (and est when RDOUT_DRAIN_EST_EN) and streams it word by word
// Optional macro RDOUT_DRAIN_EST_EN appends the est word as a final stream word.
module rdout_wout_drain #(
    parameter int WW = 32,
    parameter int NW = 8,
    parameter int IW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_req,
    input  logic [WW*NW-1:0] W_out,
    input  logic [WW-1:0]    est,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WW-1:0]    m_data,
    output logic [IW-1:0]    m_idx,
    output logic             m_last,
    output logic             busy,
    output logic             done,
    output logic             cap_drop
);

`ifdef RDOUT_DRAIN_EST_EN
    localparam int NT = NW + 1;
`else
    localparam int NT = NW;
    logic unused_est;
    assign unused_est = ^est;
`endif

    localparam logic [IW-1:0] LAST_IDX = IW'(NT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [WW-1:0]   shadow [NT];
    logic            load;
    logic [IW-1:0]   next_idx;
    logic [WW-1:0]   sel_word;

    logic            valid_n, last_n, busy_n, done_n, drop_n;
    logic [IW-1:0]   idx_n;
    logic [WW-1:0]   data_n;

    // Word that follows the one currently presented, fetched from the snapshot.
    always_comb begin
        next_idx = m_idx + 1'b1;
        sel_word = '0;
        for (int i = 0; i < NT; i++) begin
            if (next_idx == IW'(i)) begin
                sel_word = shadow[i];
            end
        end
    end

    always_comb begin
        state_n = state;
        valid_n = m_valid;
        idx_n   = m_idx;
        data_n  = m_data;
        last_n  = m_last;
        busy_n  = busy;
        done_n  = 1'b0;
        drop_n  = cap_drop;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (cap_req) begin
                    load    = 1'b1;
                    state_n = SEND;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                    idx_n   = '0;
                    // Snapshot is not written until this edge, so word 0 comes straight from the bus.
                    data_n  = W_out[WW-1:0];
                    last_n  = (LAST_IDX == '0);
                    drop_n  = 1'b0;
                end
            end
            SEND: begin
                if (cap_req) begin
                    drop_n = 1'b1;
                end
                if (m_valid && m_ready) begin
                    if (m_idx == LAST_IDX) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        idx_n   = '0;
                        data_n  = '0;
                        last_n  = 1'b0;
                    end else begin
                        idx_n  = next_idx;
                        data_n = sel_word;
                        last_n = (next_idx == LAST_IDX);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m_valid  <= 1'b0;
            m_idx    <= '0;
            m_data   <= '0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cap_drop <= 1'b0;
        end else begin
            state    <= state_n;
            m_valid  <= valid_n;
            m_idx    <= idx_n;
            m_data   <= data_n;
            m_last   <= last_n;
            busy     <= busy_n;
            done     <= done_n;
            cap_drop <= drop_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                shadow[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NW; i++) begin
                shadow[i] <= W_out[i*WW +: WW];
            end
`ifdef RDOUT_DRAIN_EST_EN
            shadow[NW] <= est;
`endif
        end
    end

endmodule
